vga_scan_timing: RTL and testbench

- Raster timing generator for the VGA output path. It sits directly upstream of the SoC's colour-map (tt_cm) port.
- It drives the pixel coordinate to the colour map and samples the returned 8-bit R/G/B.
- It re-times sync and blank so they align with the colour data, and drives the external VGA DAC pins.
- Default mode is 640x480@60 from the 50 MHz system clock with a divide-by-2 pixel enable.

---
 rtl/vga_scan_timing_if.sv | 33 +++
 rtl/vga_scan_timing.sv | 99 +++++++++
 tb/tb_vga_scan_timing.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/vga_scan_timing_if.sv
// Pixel-coordinate / colour-map / VGA-pin bundle for the raster timing generator.
// master = timing generator, slave = colour map plus DAC side.
interface vga_scan_timing_if;
    logic [9:0] draw_x;
    logic [9:0] draw_y;
    logic [7:0] cm_r;
    logic [7:0] cm_g;
    logic [7:0] cm_b;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       vga_hs_n;
    logic       vga_vs_n;
    logic       vga_blank_n;
    logic       vga_sync_n;
    logic       vga_clk;
    logic       pix_en;
    logic       frame_start;

    modport master (
        output draw_x, draw_y,
        input  cm_r, cm_g, cm_b,
        output vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n, vga_blank_n, vga_sync_n,
        output vga_clk, pix_en, frame_start
    );

    modport slave (
        input  draw_x, draw_y,
        output cm_r, cm_g, cm_b,
        input  vga_r, vga_g, vga_b, vga_hs_n, vga_vs_n, vga_blank_n, vga_sync_n,
        input  vga_clk, pix_en, frame_start
    );
endinterface

// File: rtl/vga_scan_timing.sv
// Raster timing generator: pixel divider, h/v counters, colour-map sampling and
// a pixel-tick delay line that keeps sync, blank and colour on one latency.
module vga_scan_timing #(
    parameter int unsigned CLK_DIV     = 2,
    parameter int unsigned H_VIS       = 640,
    parameter int unsigned H_FP        = 16,
    parameter int unsigned H_SYNC      = 96,
    parameter int unsigned H_BP        = 48,
    parameter int unsigned V_VIS       = 480,
    parameter int unsigned V_FP        = 10,
    parameter int unsigned V_SYNC      = 2,
    parameter int unsigned V_BP        = 33,
    parameter int unsigned EXTRA_DELAY = 0
) (
    input logic               clk_clk,
    input logic               reset_reset,
    vga_scan_timing_if.master bus
);
    localparam int unsigned H_TOTAL = H_VIS + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_VIS + V_FP + V_SYNC + V_BP;
    localparam int unsigned DIV_W   = $clog2(CLK_DIV);

    localparam logic [DIV_W-1:0] DIV_MAX  = DIV_W'(CLK_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_HALF = DIV_W'(CLK_DIV / 2);
    localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

    localparam logic [9:0] H_MAX    = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_MAX    = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS_C  = 10'(H_VIS);
    localparam logic [9:0] V_VIS_C  = 10'(V_VIS);
    localparam logic [9:0] HS_START = 10'(H_VIS + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_VIS + H_FP + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VIS + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_VIS + V_FP + V_SYNC);

    // Stage word layout: {rgb[23:0], hs_n, vs_n, blank_n}
    localparam logic [26:0] STAGE_RST = {24'h000000, 1'b1, 1'b1, 1'b0};

    logic [DIV_W-1:0] div_cnt;
    logic [9:0]       h_cnt;
    logic [9:0]       v_cnt;
    logic             pix_en;
    logic             vga_clk_q;
    logic             frame_start_q;
    logic             vis;
    logic             hs0_n;
    logic             vs0_n;
    logic [26:0]      stage0_d;
    logic [26:0]      pipe [EXTRA_DELAY+1];

    assign pix_en   = (div_cnt == DIV_MAX) && !reset_reset;
    assign vis      = (h_cnt < H_VIS_C) && (v_cnt < V_VIS_C);
    assign hs0_n    = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs0_n    = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    // cm_* is don't-care outside the visible area, so mask it before capture
    assign stage0_d = {vis ? {bus.cm_r, bus.cm_g, bus.cm_b} : 24'h000000, hs0_n, vs0_n, vis};

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            div_cnt       <= '0;
            h_cnt         <= '0;
            v_cnt         <= '0;
            vga_clk_q     <= 1'b0;
            frame_start_q <= 1'b0;
            for (int i = 0; i <= int'(EXTRA_DELAY); i++) begin
                pipe[i] <= STAGE_RST;
            end
        end else begin
            div_cnt       <= pix_en ? '0 : div_cnt + DIV_ONE;
            vga_clk_q     <= (div_cnt >= DIV_HALF);
            frame_start_q <= pix_en && (h_cnt == H_MAX) && (v_cnt == V_MAX);
            if (pix_en) begin
                if (h_cnt == H_MAX) begin
                    h_cnt <= '0;
                    v_cnt <= (v_cnt == V_MAX) ? 10'd0 : v_cnt + 10'd1;
                end else begin
                    h_cnt <= h_cnt + 10'd1;
                end
                pipe[0] <= stage0_d;
                for (int i = 1; i <= int'(EXTRA_DELAY); i++) begin
                    pipe[i] <= pipe[i-1];
                end
            end
        end
    end

    assign bus.draw_x      = h_cnt;
    assign bus.draw_y      = v_cnt;
    assign bus.vga_r       = pipe[EXTRA_DELAY][26:19];
    assign bus.vga_g       = pipe[EXTRA_DELAY][18:11];
    assign bus.vga_b       = pipe[EXTRA_DELAY][10:3];
    assign bus.vga_hs_n    = pipe[EXTRA_DELAY][2];
    assign bus.vga_vs_n    = pipe[EXTRA_DELAY][1];
    assign bus.vga_blank_n = pipe[EXTRA_DELAY][0];
    assign bus.vga_sync_n  = 1'b0;
    assign bus.vga_clk     = vga_clk_q;
    assign bus.pix_en      = pix_en;
    assign bus.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_scan_timing.sv
// Bench for vga_scan_timing: a small-raster build and an EXTRA_DELAY=2 build run side by side
// against a pixel-index model plus hand-computed edge timings.
module tb_vga_scan_timing;
    localparam int HV = 8;
    localparam int HF = 2;
    localparam int HS = 3;
    localparam int HB = 2;
    localparam int VV = 4;
    localparam int VF = 1;
    localparam int VS = 2;
    localparam int VB = 1;
    localparam int HT = 15;
    localparam int VT = 8;
    localparam int FT = 120;

    // Hand-computed for CLK_DIV=2, counted in clk edges from the last reset edge
    localparam int HS_FIRST0 = 22;   // (h=10 +1 tick) * 2
    localparam int HS_FIRST2 = 26;   // plus 2 extra ticks
    localparam int HS_PERIOD = 30;
    localparam int HS_LOW    = 6;
    localparam int VS_FIRST0 = 152;  // (pixel 75 +1 tick) * 2
    localparam int VS_LOW    = 60;
    localparam int VS_PERIOD = 240;
    localparam int FS_FIRST  = 240;
    localparam int FS_PERIOD = 240;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    vga_scan_timing_if bus0 ();
    vga_scan_timing_if bus2 ();

    vga_scan_timing #(
        .CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .EXTRA_DELAY(0)
    ) dut0 (
        .clk_clk    (clk),
        .reset_reset(rst),
        .bus        (bus0)
    );

    vga_scan_timing #(
        .CLK_DIV(2), .H_VIS(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_VIS(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .EXTRA_DELAY(2)
    ) dut2 (
        .clk_clk    (clk),
        .reset_reset(rst),
        .bus        (bus2)
    );

    // Registered colour map; returns all-ones off-screen so masking is visible
    function automatic logic [23:0] cmap(input logic [9:0] x, input logic [9:0] y);
        if (x < 10'(HV) && y < 10'(VV)) return {x[7:0], y[7:0], x[7:0] ^ y[7:0]};
        return 24'hFFFFFF;
    endfunction

    always @(posedge clk) begin
        {bus0.cm_r, bus0.cm_g, bus0.cm_b} <= cmap(bus0.draw_x, bus0.draw_y);
        {bus2.cm_r, bus2.cm_g, bus2.cm_b} <= cmap(bus2.draw_x, bus2.draw_y);
    end

    // {rgb, hs_n, vs_n, blank_n} for linear pixel index p; p < 0 means reset values
    function automatic logic [26:0] exp_pins(input int p);
        int h;
        int v;
        logic vis;
        if (p < 0) return {24'h000000, 1'b1, 1'b1, 1'b0};
        h = p % HT;
        v = (p / HT) % VT;
        vis = (h < HV) && (v < VV);
        return {vis ? {h[7:0], v[7:0], h[7:0] ^ v[7:0]} : 24'h000000,
                !(h >= HV + HF && h < HV + HF + HS),
                !(v >= VV + VF && v < VV + VF + VS), vis};
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    // n = clk edges since the last reset edge (0 while reset is held)
    task automatic check_cycle(input int n);
        int m;
        m = n / 2;
        check("draw_x", bus0.draw_x, m % HT);
        check("draw_y", bus0.draw_y, (m / HT) % VT);
        check("pix_en", bus0.pix_en, n % 2);
        check("vga_clk", bus0.vga_clk, n > 0 && n % 2 == 0);
        check("frame_start", bus0.frame_start, n % 2 == 0 && m > 0 && m % FT == 0);
        check("sync_n", bus0.vga_sync_n, 0);
        check("pins0", {bus0.vga_r, bus0.vga_g, bus0.vga_b, bus0.vga_hs_n, bus0.vga_vs_n,
                        bus0.vga_blank_n}, exp_pins(m - 1));
        check("d2_draw", {bus2.draw_x, bus2.draw_y}, {10'(m % HT), 10'((m / HT) % VT)});
        check("d2_frame_start", bus2.frame_start, n % 2 == 0 && m > 0 && m % FT == 0);
        check("d2_sync_n", bus2.vga_sync_n, 0);
        check("pins2", {bus2.vga_r, bus2.vga_g, bus2.vga_b, bus2.vga_hs_n, bus2.vga_vs_n,
                        bus2.vga_blank_n}, exp_pins(m - 3));
    endtask

    logic prev_hs0, prev_vs0, prev_hs2;
    int   last_hs, last_vs, last_fs, hs_falls, vs_falls, fs_cnt;
    bit   hs2_seen;

    task automatic track(input int n);
        if (prev_hs0 && !bus0.vga_hs_n) begin
            if (hs_falls == 0) check("hs_first_fall", n, HS_FIRST0);
            else check("hs_period", n - last_hs, HS_PERIOD);
            last_hs = n;
            hs_falls++;
        end
        if (!prev_hs0 && bus0.vga_hs_n && hs_falls > 0) check("hs_low", n - last_hs, HS_LOW);
        if (prev_vs0 && !bus0.vga_vs_n) begin
            if (vs_falls == 0) check("vs_first_fall", n, VS_FIRST0);
            else check("vs_period", n - last_vs, VS_PERIOD);
            last_vs = n;
            vs_falls++;
        end
        if (!prev_vs0 && bus0.vga_vs_n && vs_falls > 0) check("vs_low", n - last_vs, VS_LOW);
        if (prev_hs2 && !bus2.vga_hs_n && !hs2_seen) begin
            check("hs2_first_fall", n, HS_FIRST2);
            hs2_seen = 1'b1;
        end
        if (bus0.frame_start) begin
            if (fs_cnt == 0) check("fs_first", n, FS_FIRST);
            else check("fs_period", n - last_fs, FS_PERIOD);
            last_fs = n;
            fs_cnt++;
        end
        prev_hs0 = bus0.vga_hs_n;
        prev_vs0 = bus0.vga_vs_n;
        prev_hs2 = bus2.vga_hs_n;
    endtask

    task automatic run_phase(input int ncyc, input int exp_hs, input int exp_vs,
                             input int exp_fs);
        prev_hs0 = 1'b1;
        prev_vs0 = 1'b1;
        prev_hs2 = 1'b1;
        hs_falls = 0;
        vs_falls = 0;
        fs_cnt = 0;
        hs2_seen = 1'b0;
        for (int n = 1; n <= ncyc; n++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(n);
            track(n);
        end
        check("hs_fall_count", hs_falls, exp_hs);
        check("vs_fall_count", vs_falls, exp_vs);
        check("fs_count", fs_cnt, exp_fs);
        check("hs2_seen", hs2_seen, 1);
    endtask

    task automatic hold_reset(input int cycles);
        rst = 1'b1;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk);
            @(negedge clk);
            check_cycle(0);
        end
        rst = 1'b0;
    endtask

    initial begin
        hold_reset(3);
        // 550 edges lands right after the tick that presents (5, 2)
        run_phase(550, 18, 2, 2);
        check("mid_draw_x", bus0.draw_x, 5);
        check("mid_draw_y", bus0.draw_y, 2);
        hold_reset(3);
        run_phase(600, 20, 2, 2);
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
